vid_cnt2axis: RTL

//  Consumes the vcnt/hcnt position stream from the sync-to-counter stage plus pixel data on the same cycle.

---
 rtl/vid_pkg.sv | 14 +
 rtl/vid_fifo_fwft.sv | 54 +++++
 rtl/vid_cnt2axis.sv | 119 +++++++++++
 3 files changed

// File: rtl/vid_pkg.sv
// Shared types and helpers for the vid_* counter-driven video stages.
package vid_pkg;

    typedef enum logic [1:0] {
        WAIT_SOF = 2'd0,
        RUN      = 2'd1,
        DROP     = 2'd2
    } state_t;

    function automatic logic vid_active(input int h, input int v, input int h_act, input int v_act);
        return (h < h_act) && (v < v_act);
    endfunction

endpackage

// File: rtl/vid_fifo_fwft.sv
// Generic synchronous first-word-fall-through FIFO; rd_data is valid whenever empty is low.
// Latency: a write at edge t is visible on rd_data after edge t.
// Backpressure: writes while full are accepted only when a read frees the slot in the same cycle.
module vid_fifo_fwft #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    output logic             full,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             wr_ok;
    logic             rd_ok;

    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);
    assign rd_ok = rd_en && !empty;
    assign wr_ok = wr_en && (!full || rd_ok);
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
            if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: the pointers define which entries are meaningful.
    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/vid_cnt2axis.sv
// Turns a vcnt/hcnt/pixel stream into AXI4-Stream video (tuser=SOF, tlast=EOL).
// Latency: pixel at input cycle t is written to the FIFO at edge t+2.
// Backpressure: absorbed by the FIFO; on overflow pixels are dropped until the next frame start.
module vid_cnt2axis
    import vid_pkg::*;
#(
    parameter int H_ACTIVE   = -1,
    parameter int H_FRAME    = -1,
    parameter int V_ACTIVE   = -1,
    parameter int V_FRAME    = -1,
    parameter int DATA_WIDTH = 24,
    parameter int FIFO_DEPTH = 16,
    localparam int HW = (H_FRAME > 1) ? $clog2(H_FRAME) : 1,
    localparam int VW = (V_FRAME > 1) ? $clog2(V_FRAME) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [VW-1:0]         in_vcnt,
    input  logic [HW-1:0]         in_hcnt,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_ovf_clr,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tuser,
    output logic                  m_axis_tlast,
    output logic                  out_overflow
);

    localparam int FW = DATA_WIDTH + 2;

    logic                  s1_act;
    logic                  s1_sof;
    logic                  s1_eol;
    logic [DATA_WIDTH-1:0] s1_data;

    state_t                state;
    state_t                state_nxt;
    logic                  wr_en;
    logic                  set_ovf;
    logic                  can_wr;

    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  rd_en;
    logic [FW-1:0]         fifo_rd_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_act  <= 1'b0;
            s1_sof  <= 1'b0;
            s1_eol  <= 1'b0;
            s1_data <= '0;
        end else begin
            s1_act  <= vid_active(int'(in_hcnt), int'(in_vcnt), H_ACTIVE, V_ACTIVE);
            s1_sof  <= (in_hcnt == '0) && (in_vcnt == '0);
            s1_eol  <= (int'(in_hcnt) == H_ACTIVE - 1);
            s1_data <= in_data;
        end
    end

    assign rd_en  = m_axis_tready && !fifo_empty;
    // A full FIFO still takes the write when the sink drains an entry on the same edge.
    assign can_wr = !fifo_full || rd_en;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= WAIT_SOF;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        wr_en     = 1'b0;
        set_ovf   = 1'b0;
        if (s1_act) begin
            case (state)
                RUN: begin
                    if (can_wr) begin
                        wr_en = 1'b1;
                    end else begin
                        set_ovf   = 1'b1;
                        state_nxt = DROP;
                    end
                end
                WAIT_SOF, DROP: begin
                    if (s1_sof && can_wr) begin
                        wr_en     = 1'b1;
                        state_nxt = RUN;
                    end
                end
                default: state_nxt = WAIT_SOF;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)             out_overflow <= 1'b0;
        else if (set_ovf)    out_overflow <= 1'b1;
        else if (in_ovf_clr) out_overflow <= 1'b0;
    end

    vid_fifo_fwft #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_data ({s1_sof, s1_eol, s1_data}),
        .full    (fifo_full),
        .rd_en   (rd_en),
        .rd_data (fifo_rd_data),
        .empty   (fifo_empty)
    );

    assign m_axis_tvalid = !fifo_empty;
    assign {m_axis_tuser, m_axis_tlast, m_axis_tdata} = fifo_empty ? '0 : fifo_rd_data;

endmodule
